// File: rtl/motor_pwm_controller.sv
// Motor PWM generator: 15-slot registered PWM whose duty follows a 4-bit setpoint at period boundaries.
// Optional MOTOR_PWM_RAMP_EN adds a ramp FSM stepping the duty by 1 every RAMP_PERIODS periods.
module motor_pwm_controller #(
    parameter int PRESCALE     = 3334,
    parameter int RAMP_PERIODS = 8
) (
    input  logic       FPGA_clk,
    input  logic       FPGA_reset,
    input  logic [3:0] cmd_data,
    input  logic       cmd_valid,
    output logic       pwm_out,
    output logic [3:0] duty_current,
    output logic       busy,
    output logic [1:0] dbg_state
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_RAMP_DOWN = 2'd2
    } state_t;

    if (PRESCALE < 1 || RAMP_PERIODS < 1) begin : g_param_check
        $error("motor_pwm_controller: PRESCALE and RAMP_PERIODS must be >= 1");
    end

    logic [PS_W-1:0] r_presc;
    logic [3:0]      r_slot;
    logic [3:0]      r_target;
    logic [3:0]      r_duty;
    logic            r_pwm;
    logic            r_busy;
    logic            w_slot_tick;
    logic            w_period_end;

    assign w_slot_tick  = (r_presc == PS_LAST);
    assign w_period_end = w_slot_tick && (r_slot == 4'd14);

    // PWM compares against the duty already in force; duty only moves at period_end.
    always_ff @(posedge FPGA_clk) begin
        if (FPGA_reset) begin
            r_presc  <= '0;
            r_slot   <= 4'd0;
            r_pwm    <= 1'b0;
            r_target <= 4'd0;
            r_busy   <= 1'b0;
        end else begin
            r_presc <= w_slot_tick ? '0 : r_presc + 1'b1;
            if (w_slot_tick) begin
                r_slot <= (r_slot == 4'd14) ? 4'd0 : r_slot + 4'd1;
            end
            r_pwm <= (r_slot < r_duty);
            if (cmd_valid) begin
                r_target <= cmd_data;
            end
            r_busy <= (r_duty != r_target);
        end
    end

`ifdef MOTOR_PWM_RAMP_EN
    localparam int RP_W = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
    localparam logic [RP_W-1:0] RP_LAST = RP_W'(RAMP_PERIODS - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [RP_W-1:0] r_ramp_cnt;
    logic [RP_W-1:0] w_ramp_cnt_nxt;
    logic [3:0]      w_duty_nxt;

    always_ff @(posedge FPGA_clk) begin
        if (FPGA_reset) begin
            r_state    <= ST_IDLE;
            r_ramp_cnt <= '0;
            r_duty     <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_ramp_cnt <= w_ramp_cnt_nxt;
            r_duty     <= w_duty_nxt;
        end
    end

    // r_target here is still the pre-edge value, so a coincident command waits a period.
    always_comb begin
        w_state_nxt    = r_state;
        w_ramp_cnt_nxt = r_ramp_cnt;
        w_duty_nxt     = r_duty;
        if (w_period_end) begin
            case (r_state)
                ST_IDLE: begin
                    w_ramp_cnt_nxt = '0;
                    if (r_target > r_duty) begin
                        w_state_nxt = ST_RAMP_UP;
                    end else if (r_target < r_duty) begin
                        w_state_nxt = ST_RAMP_DOWN;
                    end
                end
                ST_RAMP_UP: begin
                    if (r_target == r_duty) begin
                        w_state_nxt    = ST_IDLE;
                        w_ramp_cnt_nxt = '0;
                    end else if (r_target < r_duty) begin
                        w_state_nxt = ST_RAMP_DOWN;
                    end else if (r_ramp_cnt == RP_LAST) begin
                        w_duty_nxt     = r_duty + 4'd1;
                        w_ramp_cnt_nxt = '0;
                        if (r_duty + 4'd1 == r_target) begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_ramp_cnt_nxt = r_ramp_cnt + 1'b1;
                    end
                end
                ST_RAMP_DOWN: begin
                    if (r_target == r_duty) begin
                        w_state_nxt    = ST_IDLE;
                        w_ramp_cnt_nxt = '0;
                    end else if (r_target > r_duty) begin
                        w_state_nxt = ST_RAMP_UP;
                    end else if (r_ramp_cnt == RP_LAST) begin
                        w_duty_nxt     = r_duty - 4'd1;
                        w_ramp_cnt_nxt = '0;
                        if (r_duty - 4'd1 == r_target) begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_ramp_cnt_nxt = r_ramp_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt    = ST_IDLE;
                    w_ramp_cnt_nxt = '0;
                end
            endcase
        end
    end

    assign dbg_state = r_state;
`else
    always_ff @(posedge FPGA_clk) begin
        if (FPGA_reset) begin
            r_duty <= 4'd0;
        end else if (w_period_end) begin
            r_duty <= r_target;
        end
    end

    assign dbg_state = ST_IDLE;
`endif

    assign pwm_out      = r_pwm;
    assign duty_current = r_duty;
    assign busy         = r_busy;

endmodule

// File: tb/tb_motor_pwm_controller.sv
// Directed bench for motor_pwm_controller at PRESCALE=2, RAMP_PERIODS=2 (30-clock period).
// Expectations follow whichever MOTOR_PWM_RAMP_EN setting the build uses.
module tb_motor_pwm_controller;

    localparam int PRESCALE     = 2;
    localparam int RAMP_PERIODS = 2;

    logic       FPGA_clk   = 1'b0;
    logic       FPGA_reset = 1'b1;
    logic [3:0] cmd_data   = 4'd0;
    logic       cmd_valid  = 1'b0;
    logic       pwm_out;
    logic [3:0] duty_current;
    logic       busy;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int edge_n   = 0;

    logic [3:0] exp_q[$];
    bit         sb_on   = 1'b0;
    logic [3:0] sb_last = 4'd0;

    motor_pwm_controller #(
        .PRESCALE    (PRESCALE),
        .RAMP_PERIODS(RAMP_PERIODS)
    ) dut (
        .FPGA_clk    (FPGA_clk),
        .FPGA_reset  (FPGA_reset),
        .cmd_data    (cmd_data),
        .cmd_valid   (cmd_valid),
        .pwm_out     (pwm_out),
        .duty_current(duty_current),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    // Clock and edge count since reset release (period_end lands on multiples of 30).
    always #5 FPGA_clk = ~FPGA_clk;

    always @(posedge FPGA_clk) begin
        if (FPGA_reset) edge_n = 0;
        else            edge_n = edge_n + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // Scoreboard: every change of duty_current must match the next queued value.
    always @(negedge FPGA_clk) begin
        if (sb_on && duty_current !== sb_last) begin
            if (exp_q.size() == 0) check("duty_step_extra", duty_current, sb_last);
            else                   check("duty_step", duty_current, exp_q.pop_front());
            sb_last = duty_current;
        end
    end

    task automatic do_reset();
        @(negedge FPGA_clk);
        FPGA_reset = 1'b1;
        cmd_valid  = 1'b0;
        repeat (3) @(negedge FPGA_clk);
        FPGA_reset = 1'b0;
    endtask

    task automatic goto_edge(input int k);
        while (edge_n < k) @(negedge FPGA_clk);
    endtask

    // Command is captured on edge k; returns at the negedge after edge k.
    task automatic send_cmd_at(input int k, input logic [3:0] d);
        goto_edge(k - 1);
        cmd_valid = 1'b1;
        cmd_data  = d;
        @(negedge FPGA_clk);
        cmd_valid = 1'b0;
    endtask

    task automatic count_high(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge FPGA_clk);
            c += int'(pwm_out);
        end
    endtask

    initial begin
        int hi;
        int mn;
        int mx;

        // Reset state; a command during reset must be ignored.
        repeat (2) @(negedge FPGA_clk);
        cmd_valid = 1'b1;
        cmd_data  = 4'hF;
        @(negedge FPGA_clk);
        cmd_valid  = 1'b0;
        FPGA_reset = 1'b0;
        check("rst_pwm", pwm_out, 0);
        check("rst_duty", duty_current, 0);
        check("rst_busy", busy, 0);
        count_high(200, hi);
        check("idle_pwm_200", hi, 0);
        check("idle_duty", duty_current, 0);
        check("idle_busy", busy, 0);

`ifdef MOTOR_PWM_RAMP_EN
        // Ramp up to 3: steps at period_end 90, 150, 210.
        do_reset();
        exp_q   = '{4'd1, 4'd2, 4'd3};
        sb_last = 4'd0;
        sb_on   = 1'b1;
        send_cmd_at(1, 4'd3);
        goto_edge(89);  check("up_d0", duty_current, 0);
        goto_edge(90);  check("up_d1", duty_current, 1);
        goto_edge(150); check("up_d2", duty_current, 2);
        goto_edge(209); check("up_d2_hold", duty_current, 2);
        goto_edge(210); check("up_d3", duty_current, 3);
        check("up_busy_at3", busy, 1);
        goto_edge(211); check("up_busy_fall", busy, 0);
        check("up_state_idle", dbg_state, 0);
        count_high(30, hi);
        check("up_pwm_6of30", hi, 6);
        sb_on = 1'b0;
        check("up_queue_empty", exp_q.size(), 0);

        // Reversal: heading for 8, at 4 the target drops to 2.
        do_reset();
        send_cmd_at(1, 4'h8);
        goto_edge(270); check("rev_at4", duty_current, 4);
        send_cmd_at(280, 4'h2);
        mn = int'(duty_current);
        mx = int'(duty_current);
        while (edge_n < 480) begin
            @(negedge FPGA_clk);
            if (edge_n == 300) check("rev_state_down", dbg_state, 2);
            if (edge_n == 359) check("rev_hold4", duty_current, 4);
            if (int'(duty_current) < mn) mn = int'(duty_current);
            if (int'(duty_current) > mx) mx = int'(duty_current);
        end
        check("rev_max", mx, 4);
        check("rev_min", mn, 2);
        check("rev_final", duty_current, 2);
        check("rev_state_idle", dbg_state, 0);
        check("rev_busy", busy, 0);

        // Collision: command on the period_end edge uses the old target there.
        do_reset();
        send_cmd_at(1, 4'h2);
        goto_edge(29); check("col_state_pre", dbg_state, 0);
        send_cmd_at(30, 4'h0);
        check("col_state_up", dbg_state, 1);
        goto_edge(60); check("col_state_idle", dbg_state, 0);
        check("col_duty", duty_current, 0);
        send_cmd_at(70, 4'h5);
        send_cmd_at(71, 4'h9);
        goto_edge(450); check("last_wins_d6", duty_current, 6);
        check("last_wins_busy", busy, 1);

        // Mid-ramp reset at slot 7.
        do_reset();
        send_cmd_at(1, 4'h5);
        goto_edge(150); check("mr_pre_d2", duty_current, 2);
        goto_edge(164);
        FPGA_reset = 1'b1;
        @(negedge FPGA_clk);
        check("mr_pwm", pwm_out, 0);
        check("mr_duty", duty_current, 0);
        check("mr_busy", busy, 0);
        check("mr_state", dbg_state, 0);
        @(negedge FPGA_clk);
        FPGA_reset = 1'b0;
        send_cmd_at(1, 4'h1);
        goto_edge(89); check("mr_restart_d0", duty_current, 0);
        goto_edge(90); check("mr_restart_d1", duty_current, 1);
`else
        // Limits with direct update: 15 then 0, then mid duties.
        do_reset();
        exp_q   = '{4'd15, 4'd0, 4'd3};
        sb_last = 4'd0;
        sb_on   = 1'b1;
        send_cmd_at(1, 4'hF);
        goto_edge(2);  check("lim_busy_rise", busy, 1);
        goto_edge(29); check("lim_d0", duty_current, 0);
        goto_edge(30); check("lim_d15", duty_current, 15);
        check("lim_pwm_latency", pwm_out, 0);
        goto_edge(31); check("lim_pwm_on", pwm_out, 1);
        check("lim_busy_fall", busy, 0);
        count_high(60, hi);
        check("lim_pwm_const1", hi, 60);
        send_cmd_at(100, 4'h0);
        goto_edge(120); check("lim_d0_again", duty_current, 0);
        check("lim_pwm_last_hi", pwm_out, 1);
        goto_edge(121); check("lim_pwm_off", pwm_out, 0);
        count_high(60, hi);
        check("lim_pwm_const0", hi, 0);
        send_cmd_at(185, 4'h3);
        goto_edge(210); check("mid_d3", duty_current, 3);
        count_high(30, hi);
        check("mid_pwm_6of30", hi, 6);
        sb_on = 1'b0;
        check("lim_queue_empty", exp_q.size(), 0);

        // Collision and last-wins.
        do_reset();
        send_cmd_at(1, 4'h4);
        goto_edge(30); check("col_d4", duty_current, 4);
        send_cmd_at(45, 4'h6);
        send_cmd_at(60, 4'hA);
        check("col_old_target", duty_current, 6);
        goto_edge(90); check("col_new_target", duty_current, 10);
        send_cmd_at(100, 4'h5);
        send_cmd_at(101, 4'h9);
        goto_edge(119); check("lw_hold", duty_current, 10);
        goto_edge(120); check("lw_d9", duty_current, 9);
        count_high(30, hi);
        check("lw_pwm_18of30", hi, 18);

        // Reset at slot 7 while the output is high.
        do_reset();
        send_cmd_at(1, 4'hF);
        goto_edge(164); check("mr_pre_pwm", pwm_out, 1);
        FPGA_reset = 1'b1;
        @(negedge FPGA_clk);
        check("mr_pwm", pwm_out, 0);
        check("mr_duty", duty_current, 0);
        check("mr_busy", busy, 0);
        @(negedge FPGA_clk);
        FPGA_reset = 1'b0;
        send_cmd_at(1, 4'h3);
        goto_edge(29); check("mr_restart_d0", duty_current, 0);
        goto_edge(30); check("mr_restart_d3", duty_current, 3);
        goto_edge(31);
        count_high(30, hi);
        check("mr_pwm_6of30", hi, 6);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
